// File: rtl/uart_tx_frame.sv
// UART transmit framer: latches GA/cmd/data on request, builds a 9-byte frame
// (AA 55 GA cmd data[31:0] checksum) and shifts it out as 8N1 with no inter-byte gap.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        I_clk_10M,
  input  logic        I_rst_n,
  input  logic        I_send,
  input  logic [7:0]  I_cmd,
  input  logic [31:0] I_data,
  input  logic [4:0]  GA,
  output logic        txb,
  output logic        O_busy,
  output logic        O_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [4:0]  ga_q, ga_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  csum_q, csum_d;
  logic        txb_q, txb_d;
  logic        done_q, done_d;

  logic [7:0]  csum_in;
  logic [7:0]  cur_byte;
  logic        baud_last;

  assign csum_in = {3'b000, GA} + I_cmd + I_data[31:24] + I_data[23:16]
                 + I_data[15:8] + I_data[7:0];

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    case (byte_idx_q)
      4'd0:    cur_byte = 8'hAA;
      4'd1:    cur_byte = 8'h55;
      4'd2:    cur_byte = {3'b000, ga_q};
      4'd3:    cur_byte = cmd_q;
      4'd4:    cur_byte = data_q[31:24];
      4'd5:    cur_byte = data_q[23:16];
      4'd6:    cur_byte = data_q[15:8];
      4'd7:    cur_byte = data_q[7:0];
      default: cur_byte = csum_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    ga_d       = ga_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    csum_d     = csum_q;
    txb_d      = txb_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        txb_d = 1'b1;
        if (I_send) begin
          state_d    = START;
          txb_d      = 1'b0;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          ga_d       = GA;
          cmd_d      = I_cmd;
          data_d     = I_data;
          csum_d     = csum_in;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
          txb_d      = cur_byte[0];
          shift_d    = {1'b0, cur_byte[7:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txb_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txb_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          // Stop bit flows straight into the next start bit; done only after B8.
          if (byte_idx_q < 4'd8) begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = START;
            txb_d      = 1'b0;
          end else begin
            state_d = IDLE;
            txb_d   = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        txb_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      ga_q       <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      csum_q     <= '0;
      txb_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      ga_q       <= ga_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      txb_q      <= txb_d;
      done_q     <= done_d;
    end
  end

  assign txb    = txb_q;
  assign O_busy = (state_q != IDLE);
  assign O_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one C=4 instance for most scenarios and
// one default-parameter instance for the full-rate frame.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send4, send87;
  logic [7:0]  cmd;
  logic [31:0] data;
  logic [4:0]  ga;
  logic        txb4, busy4, done4;
  logic        txb87, busy87, done87;

  int n_checks = 0;
  int n_fail   = 0;

  logic       cap_txb  [0:8191];
  logic       cap_busy [0:8191];
  logic       cap_done [0:8191];
  logic [7:0] exp_bytes [0:8];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(4)) dut4 (
    .I_clk_10M(clk), .I_rst_n(rst_n), .I_send(send4), .I_cmd(cmd),
    .I_data(data), .GA(ga), .txb(txb4), .O_busy(busy4), .O_done(done4)
  );

  uart_tx_frame dut87 (
    .I_clk_10M(clk), .I_rst_n(rst_n), .I_send(send87), .I_cmd(cmd),
    .I_data(data), .GA(ga), .txb(txb87), .O_busy(busy87), .O_done(done87)
  );

  // Reference line level for frame-relative cycle rel (1..90*c).
  function automatic logic exp_txb(input int c, input int rel);
    int k, b, p;
    k = (rel - 1) / c;
    b = k / 10;
    p = k % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return exp_bytes[b][p-1];
  endfunction

  // Number of in-frame cycles (after offset off) deviating from the reference.
  function automatic int wave_errs(input int off, input int c);
    int e;
    e = 0;
    for (int n = 1; n <= 90 * c; n++) begin
      if (cap_txb[off+n] !== exp_txb(c, n) || cap_busy[off+n] !== 1'b1 ||
          cap_done[off+n] !== 1'b0)
        e++;
    end
    return e;
  endfunction

  // Records n_cyc cycles; cycle 1 is the one after the acceptance edge.
  // Inputs are zeroed after cycle 1 so any frame must come from latched values.
  task automatic capture(input bit big, input int n_cyc, input int off_at,
                         input int pulse_at, input logic [7:0] pulse_cmd);
    for (int n = 1; n <= n_cyc; n++) begin
      @(posedge clk); #1;
      cap_txb[n]  = big ? txb87  : txb4;
      cap_busy[n] = big ? busy87 : busy4;
      cap_done[n] = big ? done87 : done4;
      if (n == 1) begin cmd = '0; data = '0; ga = '0; end
      if (n == off_at) begin send4 = 1'b0; send87 = 1'b0; end
      if (pulse_at != 0 && n == pulse_at) begin send4 = 1'b1; cmd = pulse_cmd; end
      if (pulse_at != 0 && n == pulse_at + 1) send4 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; send4 = 1'b0; send87 = 1'b0;
    cmd = '0; data = '0; ga = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({txb4, busy4, done4, txb87, busy87, done87} !== 6'b100100) begin
        n_fail++;
        $display("FAIL reset_hold: got %b required 100100",
                 {txb4, busy4, done4, txb87, busy87, done87});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({txb4, busy4, done4, txb87, busy87, done87} !== 6'b100100) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d got %b required 100100", i,
                 {txb4, busy4, done4, txb87, busy87, done87});
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] got;
    int         fe;
    ga = 5'd3; cmd = 8'h01; data = 32'h12345678;
    exp_bytes = '{8'hAA, 8'h55, 8'h03, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h18};
    send4 = 1'b1;
    capture(1'b0, 370, 1, 0, 8'h00);
    for (int b = 0; b < 9; b++) begin
      fe = 0;
      if (cap_txb[1 + b*40 + 2] !== 1'b0) fe++;
      if (cap_txb[1 + (b*10 + 9)*4 + 2] !== 1'b1) fe++;
      for (int j = 0; j < 8; j++) got[j] = cap_txb[1 + (b*10 + 1 + j)*4 + 2];
      n_checks++;
      if (got !== exp_bytes[b] || fe != 0) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got %h (framing errs %0d) required %h",
                 b, got, fe, exp_bytes[b]);
      end
    end
    n_checks++;
    if (wave_errs(0, 4) !== 0) begin
      n_fail++;
      $display("FAIL basic_wave: got %0d bad cycles required 0", wave_errs(0, 4));
    end
    n_checks++;
    if ({cap_done[361], cap_busy[361], cap_txb[361]} !== 3'b101) begin
      n_fail++;
      $display("FAIL basic_done361: got %b required 101",
               {cap_done[361], cap_busy[361], cap_txb[361]});
    end
    for (int n = 362; n <= 370; n++) begin
      n_checks++;
      if ({cap_done[n], cap_busy[n], cap_txb[n]} !== 3'b001) begin
        n_fail++;
        $display("FAIL basic_idle: cycle %0d got %b required 001", n,
                 {cap_done[n], cap_busy[n], cap_txb[n]});
      end
    end
  endtask

  task automatic test_hold_wrap();
    ga = 5'd31; cmd = 8'hFF; data = 32'hFFFFFFFF;
    exp_bytes = '{8'hAA, 8'h55, 8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1A};
    send4 = 1'b1;
    capture(1'b0, 732, 362, 0, 8'h00);
    n_checks++;
    if (wave_errs(0, 4) !== 0) begin
      n_fail++;
      $display("FAIL hold_wave1: got %0d bad cycles required 0", wave_errs(0, 4));
    end
    n_checks++;
    if ({cap_done[361], cap_busy[361], cap_txb[361]} !== 3'b101) begin
      n_fail++;
      $display("FAIL hold_done1: got %b required 101",
               {cap_done[361], cap_busy[361], cap_txb[361]});
    end
    exp_bytes = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n_checks++;
    if (wave_errs(361, 4) !== 0) begin
      n_fail++;
      $display("FAIL hold_wave2: got %0d bad cycles required 0", wave_errs(361, 4));
    end
    n_checks++;
    if ({cap_done[722], cap_busy[722], cap_txb[722]} !== 3'b101) begin
      n_fail++;
      $display("FAIL hold_done2: got %b required 101",
               {cap_done[722], cap_busy[722], cap_txb[722]});
    end
    for (int n = 723; n <= 732; n++) begin
      n_checks++;
      if ({cap_done[n], cap_busy[n], cap_txb[n]} !== 3'b001) begin
        n_fail++;
        $display("FAIL hold_no_third: cycle %0d got %b required 001", n,
                 {cap_done[n], cap_busy[n], cap_txb[n]});
      end
    end
  endtask

  task automatic test_ignored_request();
    ga = 5'd7; cmd = 8'h10; data = 32'hDEADBEEF;
    exp_bytes = '{8'hAA, 8'h55, 8'h07, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h4F};
    send4 = 1'b1;
    capture(1'b0, 381, 1, 100, 8'h22);
    n_checks++;
    if (wave_errs(0, 4) !== 0) begin
      n_fail++;
      $display("FAIL ignored_wave: got %0d bad cycles required 0", wave_errs(0, 4));
    end
    n_checks++;
    if ({cap_done[361], cap_busy[361], cap_txb[361]} !== 3'b101) begin
      n_fail++;
      $display("FAIL ignored_done: got %b required 101",
               {cap_done[361], cap_busy[361], cap_txb[361]});
    end
    for (int n = 362; n <= 381; n++) begin
      n_checks++;
      if ({cap_done[n], cap_busy[n], cap_txb[n]} !== 3'b001) begin
        n_fail++;
        $display("FAIL ignored_no_second: cycle %0d got %b required 001", n,
                 {cap_done[n], cap_busy[n], cap_txb[n]});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp0;
    ga = 5'd10; cmd = 8'h5A; data = 32'h00010203;
    exp_bytes = '{8'hAA, 8'h55, 8'h0A, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h6A};
    exp0 = exp_txb(4, 170);
    send4 = 1'b1;
    for (int n = 1; n <= 170; n++) begin
      @(posedge clk); #1;
      if (n == 1) send4 = 1'b0;
    end
    n_checks++;
    if ({txb4, busy4} !== {exp0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_before: got %b required %b", {txb4, busy4}, {exp0, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({txb4, busy4, done4} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrst_async: got %b required 100", {txb4, busy4, done4});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({txb4, busy4, done4} !== 3'b100) begin
      n_fail++;
      $display("FAIL midrst_release: got %b required 100", {txb4, busy4, done4});
    end
    ga = 5'd10; cmd = 8'h5A; data = 32'h00010203;
    send4 = 1'b1;
    capture(1'b0, 365, 1, 0, 8'h00);
    n_checks++;
    if (wave_errs(0, 4) !== 0) begin
      n_fail++;
      $display("FAIL midrst_wave: got %0d bad cycles required 0", wave_errs(0, 4));
    end
    n_checks++;
    if ({cap_done[361], cap_busy[361], cap_txb[361]} !== 3'b101) begin
      n_fail++;
      $display("FAIL midrst_done: got %b required 101",
               {cap_done[361], cap_busy[361], cap_txb[361]});
    end
  endtask

  task automatic test_default_baud();
    ga = 5'd1; cmd = 8'h02; data = 32'h00000000;
    exp_bytes = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    send87 = 1'b1;
    capture(1'b1, 7840, 1, 0, 8'h00);
    n_checks++;
    if (wave_errs(0, 87) !== 0) begin
      n_fail++;
      $display("FAIL default_wave: got %0d bad cycles required 0", wave_errs(0, 87));
    end
    n_checks++;
    if ({cap_done[7831], cap_busy[7831], cap_txb[7831]} !== 3'b101) begin
      n_fail++;
      $display("FAIL default_done7831: got %b required 101",
               {cap_done[7831], cap_busy[7831], cap_txb[7831]});
    end
    n_checks++;
    if ({cap_done[7832], cap_busy[7832], cap_txb[7832]} !== 3'b001) begin
      n_fail++;
      $display("FAIL default_after: got %b required 001",
               {cap_done[7832], cap_busy[7832], cap_txb[7832]});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold_wrap();
    test_ignored_request();
    test_mid_reset();
    test_default_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit-side framing and serialisation block for the board UART link. Takes one 32-bit payload word plus a command byte, wraps it in a fixed 9-byte frame carrying the board's geographic address (GA) and an additive checksum, and shifts it out on `txb` as 8N1 serial data. It is the return path of the UART receive chain: status and echo words travel back to the host through it.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per serial bit (10 MHz / 115200 baud). Legal range is 2 to 65535.

Ports:
- `I_clk_10M`, input, 1: system clock. All logic is on the rising edge.
- `I_rst_n`, input, 1: asynchronous active-low reset.
- `I_send`, input, 1: frame request. Sampled on each rising edge.
- `I_cmd`, input, 8: command byte for the frame.
- `I_data`, input, 32: payload word.
- `GA`, input, 5: geographic address of this board.
- `txb`, output, 1: serial output. The line idles high.
- `O_busy`, output, 1: high while a frame is in flight.
- `O_done`, output, 1: one-cycle pulse when a frame completes.

## Operation

**Reset values:** `txb`=1, `O_busy`=0, `O_done`=0. The state machine is in IDLE and all counters are 0.

**Acceptance:**
- A request is accepted on an edge where `I_send`=1 and `O_busy`=0.
- On acceptance, `I_cmd`, `I_data` and `GA` are latched. Later changes to these inputs do not affect the frame.
- `I_send` while busy is ignored. Requests are not queued.

**Frame bytes, in transmit order:**
- B0 = 0xAA
- B1 = 0x55
- B2 = {3'b000, GA}
- B3 = cmd
- B4 = data[31:24]
- B5 = data[23:16]
- B6 = data[15:8]
- B7 = data[7:0]
- B8 = checksum = (B2+B3+B4+B5+B6+B7) mod 256, an 8-bit wrap-around sum.

**Serial format:**
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
- There is no idle gap between bytes. The stop bit of byte n is followed directly by the start bit of byte n+1.

**State machine:**
- IDLE → START on acceptance.
- START → DATA after `CLKS_PER_BIT` cycles.
- DATA → STOP after 8 bit periods.
- STOP → START if the byte index is less than 8, otherwise → IDLE.
- Byte index runs 0..8. Bit index runs 0..7.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and is 16 bits wide.

**Output registering:**
- `txb` is driven from a register. It never glitches.
- `txb` is 1 in IDLE.

**Reset mid-frame:**
- `txb` returns high immediately and asynchronously. `O_busy` and `O_done` go to 0.
- The partial frame is abandoned, not resumed.

## Timing

Let the acceptance edge be cycle 0, and C = `CLKS_PER_BIT`.

- `O_busy`=1 from cycle 1 through cycle 90·C inclusive.
- `txb` holds the start bit of B0 during cycles 1..C.
- Bit k of the frame (k = 0..89) is on `txb` during cycles 1+k·C through (k+1)·C.
- `O_done`=1 only in cycle 90·C+1. In that same cycle `O_busy`=0 and `txb`=1.
- An `I_send` in the `O_done` cycle is accepted. Its start bit appears in the following cycle, so back-to-back frames are seamless.
- Total frame time is 90·C cycles: 7830 cycles (783 µs) at the default C.

## Test plan

- **Reset:** with `I_rst_n` held low, then released → `txb`=1, `O_busy`=0 and `O_done`=0 throughout. No transition on `txb` until `I_send` is asserted.
- **Basic frame:** C=4, GA=5'd3, cmd=0x01, data=0x12345678, one-cycle `I_send` → the serial decoder recovers AA 55 03 01 12 34 56 78 18. Each bit lasts exactly 4 cycles. `O_done` pulses at cycle 361. `O_busy` spans cycles 1..360.
- **Checksum wrap and input hold:** GA=5'd31, cmd=0xFF, data=0xFFFFFFFF; after acceptance, inputs change to 0 and `I_send` is held high → frame AA 55 1F FF FF FF FF FF 1A is sent unchanged. A single second frame starts right after `O_done`, because `I_send` is still high.
- **Ignored request:** pulse `I_send` with cmd=0x22 at cycle 100 of an in-flight frame → the in-flight frame completes unchanged, and no second frame is sent.
- **Mid-frame reset:** assert `I_rst_n`=0 during the data bits of B4 → `txb` goes to 1 within the same cycle, before the next edge, and `O_busy` goes to 0. After release, a new request sends a complete, correct frame.
- **Default baud:** C=87, single frame → each bit measures 87 cycles. `O_done` pulses at cycle 7831.
